// File: rtl/alu_pkg.sv
// Shared constants for the ALU / writeback pipeline: datapath sizing and ALU op encodings.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADR_W    = 3;
  localparam int NUM_REGS = 2 ** ADR_W;

  localparam logic [3:0] COP_ADD = 4'b0000;
  localparam logic [3:0] COP_SUB = 4'b0001;
  localparam logic [3:0] COP_AND = 4'b0010;
  localparam logic [3:0] COP_IMM = 4'b0011;
  localparam logic [3:0] COP_OR  = 4'b0100;
  localparam logic [3:0] COP_XOR = 4'b0101;
  localparam logic [3:0] COP_SHL = 4'b0110;
  localparam logic [3:0] COP_SHR = 4'b0111;

  function automatic logic cop_writes_reg(input logic [3:0] cop);
    return cop inside {COP_ADD, COP_SUB, COP_AND, COP_IMM, COP_OR, COP_XOR, COP_SHL, COP_SHR};
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic enable-driven pipeline register with asynchronous active-low reset to zero.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank: one synchronous write port, two combinational read ports, async clear.
module reg_bank
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADR_W-1:0]  rd_adr_a,
  input  logic [ADR_W-1:0]  rd_adr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Entry 0 is an ordinary register; there is no hardwired zero.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_adr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data_a = mem_q[rd_adr_a];
  assign rd_data_b = mem_q[rd_adr_b];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: latches ALU results, commits them to the register bank, serves two read ports.
// Define WB_BYPASS_EN to forward the pending write to the read ports in the same cycle.
module writeback_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              OVF,
  input  logic [ADR_W-1:0]  destReg_adr,
  input  logic              we,
  input  logic [ADR_W-1:0]  regA_adr,
  input  logic [ADR_W-1:0]  regB_adr,
  input  logic              clear_ovf,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regB,
  output logic              ovf_sticky,
  output logic              wb_valid,
  output logic [ADR_W-1:0]  wb_adr
);

  localparam int LATCH_W = DATA_W + ADR_W + 1;

  logic [DATA_W-1:0] wb_data_q;
  logic [ADR_W-1:0]  wb_adr_q;
  logic              wb_we_q;
  logic [DATA_W-1:0] bank_a;
  logic [DATA_W-1:0] bank_b;
  logic              ovf_d;
  logic              ovf_q;

  pipe_reg #(.W(LATCH_W)) u_wb_latch (
    .clk   (clk),
    .rst_n (reset),
    .en    (enable),
    .d     ({alu_result, destReg_adr, we}),
    .q     ({wb_data_q, wb_adr_q, wb_we_q})
  );

  // Commit ignores enable: during a stall the held value is simply rewritten.
  reg_bank u_bank (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en     (wb_we_q),
    .wr_adr    (wb_adr_q),
    .wr_data   (wb_data_q),
    .rd_adr_a  (regA_adr),
    .rd_adr_b  (regB_adr),
    .rd_data_a (bank_a),
    .rd_data_b (bank_b)
  );

`ifdef WB_BYPASS_EN
  assign regA = (wb_we_q && (wb_adr_q == regA_adr)) ? wb_data_q : bank_a;
  assign regB = (wb_we_q && (wb_adr_q == regB_adr)) ? wb_data_q : bank_b;
`else
  assign regA = bank_a;
  assign regB = bank_b;
`endif

  // A captured overflow takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (enable && OVF) ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_sticky = ovf_q;
  assign wb_valid   = wb_we_q;
  assign wb_adr     = wb_adr_q;

endmodule
